// File: rtl/md_mon_pkg.sv
// Shared types for the MD protocol monitor: rule indices, channel FSM
// states and a saturating adder used by the per-channel counters.
package md_mon_pkg;

    typedef enum int unsigned {
        VIOL_VALID_DROP    = 0,
        VIOL_FIELD_CHANGE  = 1,
        VIOL_ERR_NO_XFER   = 2,
        VIOL_ILLEGAL_ALIGN = 3,
        VIOL_STALL_TIMEOUT = 4,
        NUM_VIOL           = 5
    } md_viol_e;

    localparam int NV = int'(NUM_VIOL);

    typedef enum logic {
        MON_IDLE = 1'b0,
        MON_PEND = 1'b1
    } md_mon_state_e;

    // min(cur + inc, max_v) without wrap; counters up to 32 bits wide.
    function automatic logic [31:0] sat_add(input logic [31:0] cur,
                                            input logic [31:0] inc,
                                            input logic [31:0] max_v);
        logic [32:0] s;
        s = {1'b0, cur} + {1'b0, inc};
        return (s > {1'b0, max_v}) ? max_v : s[31:0];
    endfunction

endpackage

// File: rtl/md_mon_channel.sv
// One monitored MD channel: handshake FSM, field capture, stall counter,
// violation pulses/sticky flags, saturating counters and an irq term.
// Optional macro MD_MON_SVA_EN adds concurrent assertions for every rule.
module md_mon_channel
    import md_mon_pkg::*;
#(
    parameter int ALGN_DATA_WIDTH = 32,
    parameter int STALL_TIMEOUT   = 16,
    parameter int CNT_W           = 16,
    localparam int BUS_BYTES      = ALGN_DATA_WIDTH / 8,
    localparam int OFFSET_W       = (BUS_BYTES > 1) ? $clog2(BUS_BYTES) : 1,
    localparam int SIZE_W         = $clog2(BUS_BYTES) + 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       valid_i,
    input  logic                       ready_i,
    input  logic                       err_i,
    input  logic [ALGN_DATA_WIDTH-1:0] data_i,
    input  logic [OFFSET_W-1:0]        offset_i,
    input  logic [SIZE_W-1:0]          size_i,
    input  logic                       clr_i,
    input  logic [NV-1:0]              viol_mask_i,
    output logic [NV-1:0]              viol_pulse_o,
    output logic [NV-1:0]              viol_sticky_o,
    output logic [CNT_W-1:0]           xfer_cnt_o,
    output logic [CNT_W-1:0]           viol_cnt_o,
    output logic                       stall_active_o,
    output logic                       irq_o
);

    localparam int SUM_W   = SIZE_W + 1;
    localparam int STALL_W = $clog2(STALL_TIMEOUT + 1);
    localparam logic [STALL_W-1:0] ST_MAX = STALL_W'(STALL_TIMEOUT);
    localparam logic [STALL_W-1:0] ST_HIT = STALL_W'(STALL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;

    md_mon_state_e              state_q, state_d;
    logic [ALGN_DATA_WIDTH-1:0] cap_data_q, cap_data_d;
    logic [OFFSET_W-1:0]        cap_off_q, cap_off_d;
    logic [SIZE_W-1:0]          cap_size_q, cap_size_d;
    logic [STALL_W-1:0]         stall_q, stall_d;
    logic                       fc_done_q, fc_done_d;
    logic [NV-1:0]              pulse_q, sticky_q, sticky_d, viol;
    logic [CNT_W-1:0]           xfer_q, xfer_d, vcnt_q, vcnt_d;
    logic                       irq_q, irq_d;

    logic             hs, fields_diff, bad_align;
    logic [SUM_W-1:0] align_sum;
    logic [2:0]       npop;

    assign hs          = valid_i && ready_i;
    assign align_sum   = SUM_W'(offset_i) + SUM_W'(size_i);
    assign bad_align   = (size_i == '0) || (align_sum > SUM_W'(BUS_BYTES));
    assign fields_diff = (data_i != cap_data_q) || (offset_i != cap_off_q) ||
                         (size_i != cap_size_q);

    // Rule evaluation and FSM next state.
    always_comb begin
        state_d    = state_q;
        cap_data_d = cap_data_q;
        cap_off_d  = cap_off_q;
        cap_size_d = cap_size_q;
        stall_d    = stall_q;
        fc_done_d  = fc_done_q;
        viol       = '0;
        viol[VIOL_ERR_NO_XFER] = err_i && !hs;
        case (state_q)
            MON_IDLE: begin
                if (valid_i) begin
                    viol[VIOL_ILLEGAL_ALIGN] = bad_align;
                    if (!ready_i) begin
                        state_d    = MON_PEND;
                        cap_data_d = data_i;
                        cap_off_d  = offset_i;
                        cap_size_d = size_i;
                        stall_d    = STALL_W'(1);
                        fc_done_d  = 1'b0;
                    end
                end
            end
            default: begin
                if (!valid_i) begin
                    // Dropped valid: fields are not looked at this cycle.
                    viol[VIOL_VALID_DROP] = 1'b1;
                    state_d   = MON_IDLE;
                    stall_d   = '0;
                    fc_done_d = 1'b0;
                end else begin
                    if (fields_diff && !fc_done_q) begin
                        viol[VIOL_FIELD_CHANGE] = 1'b1;
                        fc_done_d = 1'b1;
                    end
                    if (ready_i) begin
                        state_d   = MON_IDLE;
                        stall_d   = '0;
                        fc_done_d = 1'b0;
                    end else begin
                        // Counter saturates, so the hit value is seen only once.
                        viol[VIOL_STALL_TIMEOUT] = (stall_q == ST_HIT);
                        if (stall_q != ST_MAX) stall_d = stall_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // Sticky flags, counters and irq term; clr loses to a same-cycle event.
    always_comb begin
        npop = '0;
        for (int i = 0; i < NV; i++) npop = npop + 3'(viol[i]);
        sticky_d = clr_i ? viol : (sticky_q | viol);
        xfer_d   = CNT_W'(sat_add(clr_i ? 32'd0 : 32'(xfer_q), {31'b0, hs},
                                  32'(CNT_MAX)));
        vcnt_d   = CNT_W'(sat_add(clr_i ? 32'd0 : 32'(vcnt_q), {29'b0, npop},
                                  32'(CNT_MAX)));
        irq_d    = |(sticky_d & viol_mask_i);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= MON_IDLE;
            cap_data_q <= '0;
            cap_off_q  <= '0;
            cap_size_q <= '0;
            stall_q    <= '0;
            fc_done_q  <= 1'b0;
            pulse_q    <= '0;
            sticky_q   <= '0;
            xfer_q     <= '0;
            vcnt_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cap_data_q <= cap_data_d;
            cap_off_q  <= cap_off_d;
            cap_size_q <= cap_size_d;
            stall_q    <= stall_d;
            fc_done_q  <= fc_done_d;
            pulse_q    <= viol;
            sticky_q   <= sticky_d;
            xfer_q     <= xfer_d;
            vcnt_q     <= vcnt_d;
            irq_q      <= irq_d;
        end
    end

    assign viol_pulse_o   = pulse_q;
    assign viol_sticky_o  = sticky_q;
    assign xfer_cnt_o     = xfer_q;
    assign viol_cnt_o     = vcnt_q;
    assign stall_active_o = (state_q == MON_PEND);
    assign irq_o          = irq_q;

`ifdef MD_MON_SVA_EN
    for (genvar k = 0; k < NV; k++) begin : g_sva
        a_rule: assert property (@(posedge clk) disable iff (!reset_n) !viol[k])
            else $error("%m: MD channel rule %0d violated", k);
    end
`endif

endmodule

// File: rtl/md_protocol_monitor.sv
// MD valid/ready protocol monitor over NUM_CH channels: per-channel
// checkers, output packing, clr fan-out and irq reduction.
// Optional macro MD_MON_SVA_EN enables per-channel assertions.
module md_protocol_monitor
    import md_mon_pkg::*;
#(
    parameter int ALGN_DATA_WIDTH = 32,
    parameter int NUM_CH          = 2,
    parameter int STALL_TIMEOUT   = 16,
    parameter int CNT_W           = 16,
    localparam int BUS_BYTES      = ALGN_DATA_WIDTH / 8,
    localparam int OFFSET_W       = (BUS_BYTES > 1) ? $clog2(BUS_BYTES) : 1,
    localparam int SIZE_W         = $clog2(BUS_BYTES) + 1
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_CH-1:0]                 ch_valid,
    input  logic [NUM_CH-1:0]                 ch_ready,
    input  logic [NUM_CH-1:0]                 ch_err,
    input  logic [NUM_CH*ALGN_DATA_WIDTH-1:0] ch_data,
    input  logic [NUM_CH*OFFSET_W-1:0]        ch_offset,
    input  logic [NUM_CH*SIZE_W-1:0]          ch_size,
    input  logic                              clr,
    input  logic [NV-1:0]                     viol_mask,
    output logic [NUM_CH*NV-1:0]              viol_pulse,
    output logic [NUM_CH*NV-1:0]              viol_sticky,
    output logic [NUM_CH*CNT_W-1:0]           xfer_cnt,
    output logic [NUM_CH*CNT_W-1:0]           viol_cnt,
    output logic [NUM_CH-1:0]                 stall_active,
    output logic                              irq
);

    logic [NUM_CH-1:0] ch_irq;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        md_mon_channel #(
            .ALGN_DATA_WIDTH(ALGN_DATA_WIDTH),
            .STALL_TIMEOUT  (STALL_TIMEOUT),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk           (clk),
            .reset_n       (reset_n),
            .valid_i       (ch_valid[c]),
            .ready_i       (ch_ready[c]),
            .err_i         (ch_err[c]),
            .data_i        (ch_data[c*ALGN_DATA_WIDTH +: ALGN_DATA_WIDTH]),
            .offset_i      (ch_offset[c*OFFSET_W +: OFFSET_W]),
            .size_i        (ch_size[c*SIZE_W +: SIZE_W]),
            .clr_i         (clr),
            .viol_mask_i   (viol_mask),
            .viol_pulse_o  (viol_pulse[c*NV +: NV]),
            .viol_sticky_o (viol_sticky[c*NV +: NV]),
            .xfer_cnt_o    (xfer_cnt[c*CNT_W +: CNT_W]),
            .viol_cnt_o    (viol_cnt[c*CNT_W +: CNT_W]),
            .stall_active_o(stall_active[c]),
            .irq_o         (ch_irq[c])
        );
    end

    // Per-channel irq terms are already registered; just OR them.
    assign irq = |ch_irq;

endmodule

// File: tb/tb_md_protocol_monitor.sv
// Directed bench for md_protocol_monitor (2 channels, 32-bit data, 4-bit
// counters). A transaction-level model predicts every output each cycle;
// literal expectations pin the key scenarios.
module tb_md_protocol_monitor;

    localparam int W = 32, NCH = 2, TO = 16, CW = 4, BB = 4, CMAX = 15;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  ch_valid, ch_ready, ch_err;
    logic [63:0] ch_data;
    logic [3:0]  ch_offset;
    logic [5:0]  ch_size;
    logic        clr;
    logic [4:0]  viol_mask;
    logic [9:0]  viol_pulse, viol_sticky;
    logic [7:0]  xfer_cnt, viol_cnt;
    logic [1:0]  stall_active;
    logic        irq;

    int n_chk = 0, n_fail = 0;
    bit chk_en = 1'b0;
    int hits, hit_at;

    md_protocol_monitor #(.ALGN_DATA_WIDTH(W), .NUM_CH(NCH), .STALL_TIMEOUT(TO),
                          .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .ch_valid(ch_valid), .ch_ready(ch_ready),
        .ch_err(ch_err), .ch_data(ch_data), .ch_offset(ch_offset),
        .ch_size(ch_size), .clr(clr), .viol_mask(viol_mask),
        .viol_pulse(viol_pulse), .viol_sticky(viol_sticky), .xfer_cnt(xfer_cnt),
        .viol_cnt(viol_cnt), .stall_active(stall_active), .irq(irq));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- transaction-level model ----------------
    bit          m_busy[NCH], m_fc[NCH];
    int          m_wait[NCH], m_xfer[NCH], m_vcnt[NCH], m_co[NCH], m_cs[NCH];
    logic [31:0] m_cd[NCH];
    logic [9:0]  m_pulse, m_sticky, nv;
    logic        m_irq;
    logic [1:0]  m_stall;

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int c = 0; c < NCH; c++) begin
                m_busy[c] = 0; m_fc[c] = 0; m_wait[c] = 0;
                m_xfer[c] = 0; m_vcnt[c] = 0;
            end
            m_pulse = '0; m_sticky = '0; m_irq = 0; m_stall = '0;
        end else begin
            nv = '0;
            for (int c = 0; c < NCH; c++) begin
                bit v, r, e, hs, diff;
                int off, sz, base;
                logic [31:0] d;
                v = ch_valid[c]; r = ch_ready[c]; e = ch_err[c]; hs = v && r;
                d = ch_data[c*32 +: 32];
                off = int'(ch_offset[c*2 +: 2]);
                sz = int'(ch_size[c*3 +: 3]);
                diff = (d != m_cd[c]) || (off != m_co[c]) || (sz != m_cs[c]);
                nv[c*5+2] = e && !hs;
                if (!m_busy[c]) begin
                    nv[c*5+3] = v && (sz == 0 || off + sz > BB);
                    if (v && !r) begin
                        m_busy[c] = 1; m_wait[c] = 1; m_fc[c] = 0;
                        m_cd[c] = d; m_co[c] = off; m_cs[c] = sz;
                    end
                end else if (!v) begin
                    nv[c*5+0] = 1; m_busy[c] = 0;
                end else begin
                    if (diff && !m_fc[c]) begin nv[c*5+1] = 1; m_fc[c] = 1; end
                    if (r) m_busy[c] = 0;
                    else begin
                        m_wait[c]++;
                        nv[c*5+4] = (m_wait[c] == TO);
                    end
                end
                base = clr ? 0 : m_xfer[c];
                m_xfer[c] = (base + int'(hs) > CMAX) ? CMAX : base + int'(hs);
                base = (clr ? 0 : m_vcnt[c]) + $countones(nv[c*5 +: 5]);
                m_vcnt[c] = (base > CMAX) ? CMAX : base;
                m_stall[c] = m_busy[c];
            end
            m_pulse = nv;
            m_sticky = clr ? nv : (m_sticky | nv);
            m_irq = |(m_sticky[4:0] & viol_mask) | |(m_sticky[9:5] & viol_mask);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("pulse", 64'(viol_pulse), 64'(m_pulse));
            check("sticky", 64'(viol_sticky), 64'(m_sticky));
            check("xfer_cnt", 64'(xfer_cnt), 64'({4'(m_xfer[1]), 4'(m_xfer[0])}));
            check("viol_cnt", 64'(viol_cnt), 64'({4'(m_vcnt[1]), 4'(m_vcnt[0])}));
            check("stall_active", 64'(stall_active), 64'(m_stall));
            check("irq", 64'(irq), 64'(m_irq));
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        reset_n = 0; ch_valid = '0; ch_ready = '0; ch_err = '0;
        ch_data = '0; ch_offset = '0; ch_size = 6'o44; clr = 0; viol_mask = 5'h1F;
        step(); chk_en = 1'b1; step();
        check("rst_pulse", 64'(viol_pulse), 0);
        check("rst_xfer", 64'(xfer_cnt), 0);
        check("rst_irq", 64'(irq), 0);
        reset_n = 1; step();

        // Legal transfer on ch0: 3 wait cycles then handshake.
        ch_data[31:0] = 32'hA5A5A5A5; ch_valid[0] = 1;
        step(); check("legal_stall_on", 64'(stall_active[0]), 1);
        step(); step(); check("legal_stall_3", 64'(stall_active[0]), 1);
        ch_ready[0] = 1; step();
        check("legal_stall_off", 64'(stall_active[0]), 0);
        check("legal_xfer", 64'(xfer_cnt[3:0]), 1);
        check("legal_nopulse", 64'(viol_sticky), 0);
        ch_valid[0] = 0; ch_ready[0] = 0; step();

        // Valid drop on ch1, then irq masking.
        ch_valid[1] = 1; step(); step();
        ch_valid[1] = 0; step();
        check("drop_pulse", 64'(viol_pulse), 64'h020);
        check("drop_vcnt", 64'(viol_cnt[7:4]), 1);
        check("drop_irq", 64'(irq), 1);
        step(); check("drop_one_cycle", 64'(viol_pulse), 0);
        viol_mask = 5'h00; step(); check("irq_masked", 64'(irq), 0);
        viol_mask = 5'h01; step(); check("irq_unmasked", 64'(irq), 1);
        viol_mask = 5'h1F;

        // Illegal alignment then field change on ch0.
        clr = 1; step(); clr = 0;
        check("clr_sticky", 64'(viol_sticky), 0);
        ch_offset[1:0] = 2'd1; ch_valid[0] = 1; step();
        check("align_pulse", 64'(viol_pulse), 64'h008);
        ch_data[31:0] = 32'h0; step();
        check("fc_pulse", 64'(viol_pulse), 64'h002);
        step(); check("fc_once", 64'(viol_pulse), 0);
        ch_ready[0] = 1; step();
        check("fc_xfer_pulse", 64'(viol_pulse), 0);
        check("fc_xfer", 64'(xfer_cnt[3:0]), 1);
        check("fc_vcnt", 64'(viol_cnt[3:0]), 2);
        ch_valid[0] = 0; ch_ready[0] = 0; ch_offset[1:0] = 2'd0; step();

        // Stall timeout: 20 pending cycles, then ready in the threshold cycle.
        clr = 1; step(); clr = 0;
        hits = 0; hit_at = 0; ch_valid[0] = 1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (viol_pulse[4]) begin hits++; hit_at = k; end
        end
        check("stall_once", 64'(hits), 1);
        check("stall_at", 64'(hit_at), 16);
        ch_valid[0] = 0; step();
        ch_valid[0] = 1; hits = 0;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (viol_pulse[4]) hits++;
        end
        ch_ready[0] = 1; step();
        if (viol_pulse[4]) hits++;
        check("stall_hs_wins", 64'(hits), 0);
        check("stall_hs_xfer", 64'(xfer_cnt[3:0]), 1);
        ch_valid[0] = 0; ch_ready[0] = 0; step();

        // err without handshake; clr coinciding with a new violation.
        ch_err[1] = 1; step();
        check("err_pulse", 64'(viol_pulse), 64'h080);
        ch_err[1] = 0; clr = 1; ch_err[0] = 1; step();
        check("clr_new_sticky", 64'(viol_sticky), 64'h004);
        check("clr_new_vcnt", 64'(viol_cnt), 64'h01);
        clr = 0; ch_err[0] = 0; step();

        // Counter saturation, then reset in the middle of a pending transfer.
        ch_valid[0] = 1; ch_ready[0] = 1;
        for (int k = 0; k < 20; k++) step();
        check("xfer_sat", 64'(xfer_cnt[3:0]), 15);
        ch_ready[0] = 0; step(); step();
        reset_n = 0; step();
        check("rst_mid_pulse", 64'(viol_pulse), 0);
        check("rst_mid_sticky", 64'(viol_sticky), 0);
        check("rst_mid_cnt", 64'({xfer_cnt, viol_cnt}), 0);
        check("rst_mid_stall", 64'(stall_active), 0);
        ch_valid[0] = 0; reset_n = 1; step();
        check("rst_no_drop", 64'(viol_pulse), 0);
        step();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
